gpio_irq_scheduler: RTL and testbench
=====================================

# gpio_irq_scheduler

Interrupt scheduler for the IO controller's per-pin edge-capture channels. It collects the level `irq` outputs of `N_PINS` capture channels, picks one with round-robin arbitration, and presents it to the host as a single `irq_out` with a pin index. On host acknowledge it issues a one-cycle `clr` pulse to the winning channel. It then waits for that channel's `irq` to drop before servicing the next pin.

## Interface
Parameters:
- `N_PINS`, 8: number of capture channels served.
- `ID_W`, 3: width of the pin index; must satisfy 2^ID_W >= N_PINS.
- `TIMEOUT_CYC`, 16: maximum number of DRAIN cycles. Used only with `GPIO_IRQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  scheduler enable. When low, the FSM is forced to IDLE.
- `irq_in`  in  N_PINS  level interrupt from each channel. Stays high until that channel is cleared.
- `irq_mask`  in  N_PINS  1 = pin excluded from arbitration.
- `ack`  in  1  host acknowledge. Sampled only in WAIT_ACK.
- `irq_out`  out  1  registered interrupt to the host.
- `irq_id`  out  ID_W  registered index of the pin being serviced.
- `clr_out`  out  N_PINS  one-hot, single-cycle clear pulse to the channel's `clr` input.
- `busy`  out  1  high when state != IDLE.
- `timeout_err`  out  1  sticky DRAIN-timeout flag. Constant 0 without the macro.

## Operation
- `pending = irq_in & ~irq_mask`. Evaluated combinationally every cycle.
- Round-robin pointer `last_id`:
  - Search starts at `(last_id+1) mod N_PINS`, ascending, wrapping.
  - The first pending pin wins.
  - Reset value of `last_id` is `N_PINS-1`, so pin 0 has priority first.
- FSM states: IDLE, WAIT_ACK, CLEAR, DRAIN.
  - IDLE: if `enable` and `pending != 0`, latch the winner into `irq_id`, set `irq_out=1`, go to WAIT_ACK.
  - WAIT_ACK, while `irq_out` is held at 1:
    - If `ack=1`: `irq_out` goes to 0, `last_id` takes `irq_id`, go to CLEAR.
    - Else if `pending[irq_id]=0` (source withdrew or was masked): `irq_out` goes to 0, go to IDLE. No clear is issued and `last_id` is unchanged.
  - CLEAR: `clr_out` is one-hot at `irq_id` for exactly this cycle. Next state is DRAIN.
  - DRAIN: when `irq_in[irq_id]=0`, go to IDLE. `irq_mask` is ignored here.
- Simultaneous `ack` and withdrawal in WAIT_ACK: `ack` wins, and a clear is still issued.
- `ack` outside WAIT_ACK is ignored.
- `enable=0` in any state:
  - Next state is IDLE.
  - `irq_out`, `clr_out` and `busy` are 0 after the next edge.
  - `last_id`, `irq_id` and `timeout_err` are retained.
- `irq_id` holds its last value while in IDLE.
- Reset values: `irq_out=0`, `irq_id=0`, `clr_out=0`, `busy=0`, `timeout_err=0`, state=IDLE.

## Timing
- `irq_in` is high before edge k with the FSM in IDLE → `irq_out` and `irq_id` are valid after edge k (1-cycle latency).
- `ack` is sampled high at edge m → `irq_out` is 0 after m, and `clr_out` is high for the cycle between edges m and m+1.
- Earliest next `irq_out`: the edge after `irq_in[irq_id]` is seen low in DRAIN (IDLE for one cycle in between).
- Minimum service loop is 4 cycles: IDLE → WAIT_ACK → CLEAR → DRAIN.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Configuration
Macro `GPIO_IRQ_TIMEOUT_EN`:
- Defined:
  - A DRAIN cycle counter is added, cleared on entry to DRAIN.
  - If `irq_in[irq_id]` is still high after `TIMEOUT_CYC` cycles in DRAIN, set `timeout_err=1` and go to IDLE.
  - `timeout_err` is cleared only by reset.
  - `last_id` has already advanced in WAIT_ACK, so a stuck pin cannot starve the others.
- Not defined: no counter. DRAIN waits indefinitely and `timeout_err` is tied to 0.

## Test plan
- Reset then `irq_in=8'h08`:
  - `irq_out=1`, `irq_id=3` one cycle later.
  - `ack` pulse → `clr_out=8'h08` for exactly one cycle.
  - Drop `irq_in` → `busy=0` on the next edge.
- `irq_in=8'h81` held and re-raised after each clear → service order is 0, 7, 0, 7, and `clr_out` alternates `8'h01` and `8'h80`.
- Masking:
  - `irq_in=8'h04`, `irq_mask=8'h04` → `irq_out` stays 0 for 20 cycles.
  - Set `irq_mask=0` → `irq_out=1`, `irq_id=2` on the next edge.
- Withdrawal: `irq_in[5]` falls during WAIT_ACK → `irq_out=0` on the next edge, `clr_out` never pulses, and a later `irq_in[5]` is granted before pin 6.
- `GPIO_IRQ_TIMEOUT_EN` with `TIMEOUT_CYC=16`:
  - `irq_in[1]` stuck high after the clear, `irq_in[2]` pending.
  - Expected: `timeout_err=1` after 16 DRAIN cycles, then `irq_id=2`.
  - Without the macro: `busy` stays 1.
- Enable and reset:
  - `enable=0` during WAIT_ACK → `irq_out=0` and `busy=0` on the next edge.
  - `rst_n` low mid-CLEAR → `clr_out=0` immediately (asynchronous).

Source files
------------

// File: rtl/gpio_irq_scheduler.sv
// ---------------------------------------------------------------------------
// gpio_irq_scheduler
//
// Collects the level interrupts of N_PINS edge-capture channels, picks one
// with round-robin arbitration and presents it to the host as a single
// registered interrupt plus pin index. On host acknowledge the winning
// channel gets a one-cycle clear pulse; the scheduler then waits for that
// channel's interrupt to drop before servicing the next pin.
//
// Ports:
//   clk          in   1       system clock
//   rst_n        in   1       asynchronous active-low reset
//   enable       in   1       scheduler enable; low forces the FSM to IDLE
//   irq_in       in   N_PINS  level interrupt from each channel
//   irq_mask     in   N_PINS  1 = pin excluded from arbitration
//   ack          in   1       host acknowledge (only honoured in WAIT_ACK)
//   irq_out      out  1       registered interrupt to the host
//   irq_id       out  ID_W    registered index of the pin being serviced
//   clr_out      out  N_PINS  one-hot, single-cycle clear pulse
//   busy         out  1       high whenever the FSM is not in IDLE
//   timeout_err  out  1       sticky DRAIN-timeout flag
//
// Optional feature macro: GPIO_IRQ_TIMEOUT_EN
//   Defined   : DRAIN is bounded to TIMEOUT_CYC cycles; on expiry the
//               sticky timeout_err is set and the FSM returns to IDLE.
//   Undefined : DRAIN waits indefinitely and timeout_err is tied to 0.
// ---------------------------------------------------------------------------
module gpio_irq_scheduler #(
  parameter int N_PINS      = 8,
  parameter int ID_W        = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_PINS-1:0] irq_in,
  input  logic [N_PINS-1:0] irq_mask,
  input  logic              ack,
  output logic              irq_out,
  output logic [ID_W-1:0]   irq_id,
  output logic [N_PINS-1:0] clr_out,
  output logic              busy,
  output logic              timeout_err
);

  // Reject configurations the index width or the drain counter cannot cover.
  if (TIMEOUT_CYC < 1 || (2 ** ID_W) < N_PINS) begin : g_bad_cfg
    $error("gpio_irq_scheduler: illegal N_PINS/ID_W/TIMEOUT_CYC combination");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    CLEAR    = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [ID_W-1:0]   irq_id_q, irq_id_d;
  logic              irq_out_q, irq_out_d;
  logic              busy_q, busy_d;
  logic [N_PINS-1:0] clr_out_q, clr_out_d;

  logic [N_PINS-1:0] pending;
  logic [N_PINS-1:0] id_onehot;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   rr_idx;
  logic              rr_hit;

  assign pending = irq_in & ~irq_mask;

  // One-hot decode of the serviced pin, used for the clear pulse.
  for (genvar gi = 0; gi < N_PINS; gi++) begin : g_onehot
    assign id_onehot[gi] = (irq_id_q == ID_W'(gi));
  end

  // Round-robin search: start just after the last acknowledged pin and walk
  // upwards with wrap-around; the first pending pin wins.
  always_comb begin
    winner = '0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = 1; i <= N_PINS; i++) begin
      rr_idx = ID_W'((int'(last_id_q) + i) % N_PINS);
      if (!rr_hit && pending[rr_idx]) begin
        rr_hit = 1'b1;
        winner = rr_idx;
      end
    end
  end

`ifdef GPIO_IRQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  // Next-state logic. Every output register is derived from the next state,
  // so all outputs are registered and none depends combinationally on inputs.
  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    irq_id_d  = irq_id_q;
`ifdef GPIO_IRQ_TIMEOUT_EN
    drain_cnt_d   = drain_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    if (!enable) begin
      // Disabling abandons the current service without touching the
      // round-robin pointer, the last index or the sticky error.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending) begin
            irq_id_d = winner;
            state_d  = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // Acknowledge beats a simultaneous withdrawal.
          if (ack) begin
            last_id_d = irq_id_q;
            state_d   = CLEAR;
          end else if (!pending[irq_id_q]) begin
            state_d = IDLE;
          end
        end
        CLEAR: begin
          state_d = DRAIN;
`ifdef GPIO_IRQ_TIMEOUT_EN
          drain_cnt_d = '0;
`endif
        end
        DRAIN: begin
          // Mask is deliberately ignored: we wait on the raw channel level.
          if (!irq_in[irq_id_q]) begin
            state_d = IDLE;
`ifdef GPIO_IRQ_TIMEOUT_EN
          end else if (drain_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    irq_out_d = (state_d == WAIT_ACK);
    busy_d    = (state_d != IDLE);
    clr_out_d = (state_d == CLEAR) ? id_onehot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_id_q <= ID_W'(N_PINS - 1);
      irq_id_q  <= '0;
      irq_out_q <= 1'b0;
      busy_q    <= 1'b0;
      clr_out_q <= '0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      irq_id_q  <= irq_id_d;
      irq_out_q <= irq_out_d;
      busy_q    <= busy_d;
      clr_out_q <= clr_out_d;
    end
  end

`ifdef GPIO_IRQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      drain_cnt_q   <= drain_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign irq_out = irq_out_q;
  assign irq_id  = irq_id_q;
  assign clr_out = clr_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_gpio_irq_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for gpio_irq_scheduler (N_PINS=8, ID_W=3, TIMEOUT_CYC=16).
// Expected grant indices are pushed to a queue when the interrupt pattern is
// driven and popped when the DUT raises irq_out. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_gpio_irq_scheduler;

  localparam int N    = 8;
  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [N-1:0]    irq_in;
  logic [N-1:0]    irq_mask;
  logic            ack;
  logic            irq_out;
  logic [ID_W-1:0] irq_id;
  logic [N-1:0]    clr_out;
  logic            busy;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;
  logic [ID_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  gpio_irq_scheduler #(.N_PINS(N), .ID_W(ID_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .irq_in(irq_in),
    .irq_mask(irq_mask), .ack(ack), .irq_out(irq_out), .irq_id(irq_id),
    .clr_out(clr_out), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_irq(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (irq_out === 1'b1) ok = 1'b1;
    end
  endtask

  function automatic logic [ID_W-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; ack = 1'b0; irq_in = '0; irq_mask = '0; enable = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; irq_in = 8'h08; irq_mask = '0; ack = 1'b0;
    tick(); tick();
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out got %b exp 0", irq_out); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_irq_id got %0d exp 0", irq_id); end
    checks++; if (clr_out !== 8'h00) begin errors++; $display("FAIL reset_clr_out got %h exp 00", clr_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
    irq_in = '0;
    rst_n = 1'b1;
    tick();
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_single();
    logic [ID_W-1:0] e;
    irq_in = 8'h08; exp_q.push_back(3'd3);
    tick();
    e = pop_exp();
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL single_irq_out got %b exp 1", irq_out); end
    checks++; if (irq_id !== e) begin errors++; $display("FAIL single_irq_id got %0d exp %0d", irq_id, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL single_irq_out_after_ack got %b exp 0", irq_out); end
    checks++; if (clr_out !== 8'h08) begin errors++; $display("FAIL single_clr got %h exp 08", clr_out); end
    tick();
    checks++; if (clr_out !== 8'h00) begin errors++; $display("FAIL single_clr_one_cycle got %h exp 00", clr_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_drain got %b exp 1", busy); end
    irq_in = '0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b exp 0", busy); end
    $display("single: pin %0d granted, cleared and drained", e);
  endtask

  task automatic test_round_robin();
    logic [ID_W-1:0] e;
    bit ok;
    do_reset();
    irq_in = 8'h81;
    exp_q.push_back(3'd0); exp_q.push_back(3'd7);
    exp_q.push_back(3'd0); exp_q.push_back(3'd7);
    for (int k = 0; k < 4; k++) begin
      wait_irq(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_wait_%0d irq_out got %b exp 1", k, irq_out); end
      e = pop_exp();
      checks++; if (irq_id !== e) begin errors++; $display("FAIL rr_id_%0d got %0d exp %0d", k, irq_id, e); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (clr_out !== (8'h01 << e)) begin errors++; $display("FAIL rr_clr_%0d got %h exp %h", k, clr_out, 8'h01 << e); end
      irq_in[e] = 1'b0;
      tick();
      checks++; if (clr_out !== 8'h00) begin errors++; $display("FAIL rr_clr_off_%0d got %h exp 00", k, clr_out); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_%0d busy got %b exp 0", k, busy); end
      if (k < 3) irq_in[e] = 1'b1;
      else irq_in = '0;
      $display("round_robin: service %0d granted pin %0d clr %h", k, irq_id, 8'h01 << e);
    end
  endtask

  task automatic test_mask();
    logic [ID_W-1:0] e;
    irq_mask = 8'h04; irq_in = 8'h04;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mask_hold_%0d irq_out got %b exp 0", i, irq_out); end
    end
    irq_mask = 8'h00; exp_q.push_back(3'd2);
    tick();
    e = pop_exp();
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL mask_release irq_out got %b exp 1", irq_out); end
    checks++; if (irq_id !== e) begin errors++; $display("FAIL mask_release_id got %0d exp %0d", irq_id, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0; irq_in = '0;
    checks++; if (clr_out !== 8'h04) begin errors++; $display("FAIL mask_clr got %h exp 04", clr_out); end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mask_idle busy got %b exp 0", busy); end
    $display("mask: pin 2 held off 20 cycles then granted");
  endtask

  task automatic test_withdraw();
    logic [ID_W-1:0] e;
    bit ok;
    irq_in = 8'h20; exp_q.push_back(3'd5);
    tick();
    e = pop_exp();
    checks++; if (irq_out !== 1'b1 || irq_id !== e) begin errors++; $display("FAIL wd_grant got irq_out=%b id=%0d exp 1/%0d", irq_out, irq_id, e); end
    irq_in = 8'h00;
    tick();
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL wd_irq_out got %b exp 0", irq_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_busy got %b exp 0", busy); end
    checks++; if (clr_out !== 8'h00) begin errors++; $display("FAIL wd_clr_a got %h exp 00", clr_out); end
    tick();
    checks++; if (clr_out !== 8'h00) begin errors++; $display("FAIL wd_clr_b got %h exp 00", clr_out); end
    // Pointer must not have advanced: pin 5 beats pin 6.
    irq_in = 8'h60; exp_q.push_back(3'd5); exp_q.push_back(3'd6);
    tick();
    e = pop_exp();
    checks++; if (irq_out !== 1'b1 || irq_id !== e) begin errors++; $display("FAIL wd_regrant got irq_out=%b id=%0d exp 1/%0d", irq_out, irq_id, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (clr_out !== 8'h20) begin errors++; $display("FAIL wd_clr5 got %h exp 20", clr_out); end
    irq_in = 8'h40;
    tick(); tick();
    wait_irq(4, ok);
    e = pop_exp();
    checks++; if (!ok || irq_id !== e) begin errors++; $display("FAIL wd_next got ok=%b id=%0d exp 1/%0d", ok, irq_id, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0; irq_in = '0;
    checks++; if (clr_out !== 8'h40) begin errors++; $display("FAIL wd_clr6 got %h exp 40", clr_out); end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle busy got %b exp 0", busy); end
    $display("withdraw: pin 5 withdrew without clear, then granted before pin 6");
  endtask

  task automatic test_timeout();
    logic [ID_W-1:0] e;
    irq_in = 8'h06; exp_q.push_back(3'd1);
    tick();
    e = pop_exp();
    checks++; if (irq_out !== 1'b1 || irq_id !== e) begin errors++; $display("FAIL to_grant got irq_out=%b id=%0d exp 1/%0d", irq_out, irq_id, e); end
    exp_q.push_back(3'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (clr_out !== 8'h02) begin errors++; $display("FAIL to_clr got %h exp 02", clr_out); end
`ifdef GPIO_IRQ_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_drain_%0d got busy=%b err=%b exp 1/0", i, busy, timeout_err); end
    end
    tick();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_expire got err=%b busy=%b exp 1/0", timeout_err, busy); end
`else
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_stuck_%0d got busy=%b err=%b exp 1/0", i, busy, timeout_err); end
    end
    irq_in = 8'h04;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_release busy got %b exp 0", busy); end
`endif
    tick();
    e = pop_exp();
    checks++; if (irq_out !== 1'b1 || irq_id !== e) begin errors++; $display("FAIL to_next got irq_out=%b id=%0d exp 1/%0d", irq_out, irq_id, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0; irq_in = '0;
    checks++; if (clr_out !== 8'h04) begin errors++; $display("FAIL to_clr2 got %h exp 04", clr_out); end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle busy got %b exp 0", busy); end
`ifdef GPIO_IRQ_TIMEOUT_EN
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", timeout_err); end
`endif
    $display("timeout: stuck pin 1 then pin 2 granted, timeout_err=%b", timeout_err);
  endtask

  task automatic test_enable();
    logic [ID_W-1:0] e;
    irq_in = 8'h10; exp_q.push_back(3'd4);
    tick();
    e = pop_exp();
    checks++; if (irq_out !== 1'b1 || irq_id !== e) begin errors++; $display("FAIL en_grant got irq_out=%b id=%0d exp 1/%0d", irq_out, irq_id, e); end
    // ack while disabling must not advance the pointer.
    enable = 1'b0; ack = 1'b1; irq_in = 8'h30;
    tick();
    ack = 1'b0;
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL en_irq_out got %b exp 0", irq_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy got %b exp 0", busy); end
    checks++; if (clr_out !== 8'h00) begin errors++; $display("FAIL en_clr got %h exp 00", clr_out); end
    checks++; if (irq_id !== 3'd4) begin errors++; $display("FAIL en_id_hold got %0d exp 4", irq_id); end
    enable = 1'b1; exp_q.push_back(3'd4);
    tick();
    e = pop_exp();
    checks++; if (irq_out !== 1'b1 || irq_id !== e) begin errors++; $display("FAIL en_regrant got irq_out=%b id=%0d exp 1/%0d", irq_out, irq_id, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (clr_out !== 8'h10) begin errors++; $display("FAIL en_clr4 got %h exp 10", clr_out); end
    $display("enable: disable dropped irq_out, pointer retained, pin 4 regranted");
  endtask

  task automatic test_reset_mid_clear();
    logic [ID_W-1:0] e;
    irq_in = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (clr_out !== 8'h00) begin errors++; $display("FAIL rst_clr got %h exp 00", clr_out); end
    checks++; if (busy !== 1'b0 || irq_out !== 1'b0) begin errors++; $display("FAIL rst_busy got busy=%b irq_out=%b exp 0/0", busy, irq_out); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", irq_id); end
    tick();
    rst_n = 1'b1;
    irq_in = 8'h11; exp_q.push_back(3'd0);
    tick();
    e = pop_exp();
    checks++; if (irq_out !== 1'b1 || irq_id !== e) begin errors++; $display("FAIL rst_regrant got irq_out=%b id=%0d exp 1/%0d", irq_out, irq_id, e); end
    ack = 1'b1;
    tick();
    ack = 1'b0; irq_in = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle busy got %b exp 0", busy); end
    $display("reset_mid_clear: clr_out dropped asynchronously, pin 0 has priority again");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_withdraw();
    test_timeout();
    test_enable();
    test_reset_mid_clear();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
